// File: rtl/scan_master.sv
// Debug scan-chain master: captures every chain element's status byte, shifts the chain back,
// commits a byte-addressable snapshot with a per-byte changed mask. Define SCAN_AUTO_EN for periodic scans.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start or a pending auto trigger
// LOAD    | one-cycle dbg_load strobe, chain elements capture status
// SHIFT   | 8*N cycles of dbg_shift, dbg_din sampled into the capture reg
// COMMIT  | capture copied to snapshot, changed mask updated, done pulsed
module scan_master #(
  parameter int N = 3,
  parameter int PERIOD = 500000,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clkDebug,
  input  logic          n_reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          dbg_load,
  output logic          dbg_shift,
  output logic          dbg_dout,
  input  logic          dbg_din,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [N-1:0]  changed
);

  localparam int CW = $clog2(8 * N);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  if (N < 1) begin : g_bad_n
    $error("scan_master: N must be at least 1");
  end
  if (PERIOD < 1) begin : g_bad_period
    $error("scan_master: PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SHIFT  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   bit_cnt;
  logic [8*N-1:0]  cap;
  logic [8*N-1:0]  cap_nxt;
  logic [8*N-1:0]  snap;
  logic            trig;
  logic            enter_load;
  logic            enter_commit;

  assign enter_load   = (state == S_IDLE) && (state_nxt == S_LOAD);
  assign enter_commit = (state == S_SHIFT) && (state_nxt == S_COMMIT);

`ifdef SCAN_AUTO_EN
  logic [PW-1:0] auto_cnt;
  logic          auto_pend;

  // A tick landing on the same edge as a LOAD entry stays pending for the next scan.
  always_ff @(posedge clkDebug or negedge n_reset) begin
    if (!n_reset) begin
      auto_cnt  <= PW'(PERIOD - 1);
      auto_pend <= 1'b0;
    end else begin
      if (auto_cnt == '0) begin
        auto_cnt  <= PW'(PERIOD - 1);
        auto_pend <= 1'b1;
      end else begin
        auto_cnt <= auto_cnt - PW'(1);
        if (enter_load) begin
          auto_pend <= 1'b0;
        end
      end
    end
  end

  assign trig = auto_pend;
`else
  assign trig = 1'b0;
`endif

  always_ff @(posedge clkDebug or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start || trig) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SHIFT;
      S_SHIFT:  if (bit_cnt == '0) state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Final bit arrives on the edge entering COMMIT, so the snapshot takes cap_nxt directly.
  assign cap_nxt = {cap[8*N-2:0], dbg_din};

  always_ff @(posedge clkDebug or negedge n_reset) begin
    if (!n_reset) begin
      bit_cnt <= '0;
      cap     <= '0;
      snap    <= '0;
      changed <= '0;
    end else begin
      if (state == S_LOAD) begin
        bit_cnt <= CW'(8 * N - 1);
      end else if ((state == S_SHIFT) && (bit_cnt != '0)) begin
        bit_cnt <= bit_cnt - CW'(1);
      end
      if (state == S_SHIFT) begin
        cap <= cap_nxt;
      end
      if (enter_commit) begin
        snap <= cap_nxt;
        for (int i = 0; i < N; i++) begin
          changed[i] <= (cap_nxt[8*(N-1-i) +: 8] != snap[8*(N-1-i) +: 8]);
        end
      end
    end
  end

  always_ff @(posedge clkDebug or negedge n_reset) begin
    if (!n_reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      dbg_load  <= 1'b0;
      dbg_shift <= 1'b0;
    end else begin
      busy      <= (state_nxt == S_LOAD) || (state_nxt == S_SHIFT);
      done      <= (state_nxt == S_COMMIT);
      dbg_load  <= (state_nxt == S_LOAD);
      dbg_shift <= (state_nxt == S_SHIFT);
    end
  end

  assign dbg_dout = 1'b0;

  // Byte 0 sits at the top of the snapshot; addresses past N-1 read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_data = snap[8*(N-1-i) +: 8];
      end
    end
  end

endmodule
